axis_unfilter: RTL and testbench

Re-expands a stream that was thinned by the filter stage back to its original sample rate. For each flag beat, it either forwards the next sample from the filtered stream or inserts a filler sample where the filter removed one. It sits on the decompression side, taking the same flag stream the filter consumed. It also holds a 2-entry output buffer, so neither input ready depends combinationally on `output_ready`.

---
 rtl/axis_unfilter.sv | 109 ++++++++++
 tb/tb_axis_unfilter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_unfilter.sv
`default_nettype none
// ============================================================================
// Module   : axis_unfilter
// Purpose  : Re-expands a thinned AXI-Stream back to its original sample rate.
//            Each flag beat either forwards the next filtered sample (pass) or
//            inserts a filler (fill). A 2-entry output buffer decouples the
//            input ready signals from output_ready.
// Revision : 1.0 - initial release
// ============================================================================
module axis_unfilter #(
    parameter int                    DATA_WIDTH      = 16,
    parameter logic                  ELIMINATE_ON_UP = 1'b1,
    parameter int                    FILL_MODE       = 0,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE      = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_valid,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  input_ready,
    input  logic                  flag_valid,
    input  logic                  flag_data,
    output logic                  flag_ready,
    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data,
    input  logic                  output_ready
);

    localparam logic [1:0] C_OCC_EMPTY = 2'd0;
    localparam logic [1:0] C_OCC_ONE   = 2'd1;
    localparam logic [1:0] C_OCC_FULL  = 2'd2;

    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] r_last;

    logic                  w_elim;
    logic                  w_space;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_fill;
    logic [DATA_WIDTH-1:0] w_push_data;

    // Room in the buffer depends only on registered occupancy; reset forces
    // both readies low while rst is held.
    assign w_elim  = flag_valid && (flag_data == ELIMINATE_ON_UP);
    assign w_space = rst && (r_count < C_OCC_FULL);

    assign flag_ready  = w_space && flag_valid && (w_elim || input_valid);
    assign input_ready = w_space && flag_valid && !w_elim && input_valid;

    // Every flag transfer pushes exactly one value into the buffer.
    assign w_push      = flag_ready;
    assign w_pop       = output_valid && output_ready;
    assign w_fill      = (FILL_MODE == 0) ? FILL_VALUE : r_last;
    assign w_push_data = w_elim ? w_fill : input_data;

    assign output_valid = (r_count != C_OCC_EMPTY);
    assign output_data  = r_head;

    // Track the most recently pushed sample for repeat-fill mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= FILL_VALUE;
        end else if (w_push) begin
            r_last <= w_push_data;
        end
    end

    // Two-entry output buffer; head is the presented beat, tail the spare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= C_OCC_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_count)
                C_OCC_EMPTY: begin
                    if (w_push) begin
                        r_head  <= w_push_data;
                        r_count <= C_OCC_ONE;
                    end
                end
                C_OCC_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= w_push_data;
                    end else if (w_push) begin
                        r_tail  <= w_push_data;
                        r_count <= C_OCC_FULL;
                    end else if (w_pop) begin
                        r_count <= C_OCC_EMPTY;
                    end
                end
                C_OCC_FULL: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= C_OCC_ONE;
                    end
                end
                default: begin
                    r_count <= C_OCC_EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_unfilter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_unfilter
// Purpose  : Scoreboard bench for axis_unfilter. Two instances share stimulus:
//            dut_a uses constant fill 16'hFFFF, dut_b repeats the last sample
//            with initial value 7.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_unfilter;

    typedef struct packed {
        logic [15:0] d;
        logic [31:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        input_valid = 1'b0;
    logic [15:0] input_data = '0;
    logic        flag_valid = 1'b0;
    logic        flag_data = 1'b0;
    logic        output_ready = 1'b0;

    logic        input_ready_a, flag_ready_a, output_valid_a;
    logic [15:0] output_data_a;
    logic        input_ready_b, flag_ready_b, output_valid_b;
    logic [15:0] output_data_b;

    int   checks = 0;
    int   errors = 0;
    logic [31:0] cyc = '0;
    bit   lat_en = 1'b1;
    int   in_xfer = 0;
    int   flag_xfer = 0;

    exp_t qa[$];
    exp_t qb[$];

    bit          hold_a = 1'b0, hold_b = 1'b0;
    logic [15:0] hold_da = '0, hold_db = '0;

    axis_unfilter #(
        .DATA_WIDTH(16), .ELIMINATE_ON_UP(1'b1), .FILL_MODE(0), .FILL_VALUE(16'hFFFF)
    ) dut_a (
        .clk(clk), .rst(rst),
        .input_valid(input_valid), .input_data(input_data), .input_ready(input_ready_a),
        .flag_valid(flag_valid), .flag_data(flag_data), .flag_ready(flag_ready_a),
        .output_valid(output_valid_a), .output_data(output_data_a), .output_ready(output_ready)
    );

    axis_unfilter #(
        .DATA_WIDTH(16), .ELIMINATE_ON_UP(1'b1), .FILL_MODE(1), .FILL_VALUE(16'd7)
    ) dut_b (
        .clk(clk), .rst(rst),
        .input_valid(input_valid), .input_data(input_data), .input_ready(input_ready_b),
        .flag_valid(flag_valid), .flag_data(flag_data), .flag_ready(flag_ready_b),
        .output_valid(output_valid_b), .output_data(output_data_b), .output_ready(output_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && flag_valid && flag_ready_a) flag_xfer <= flag_xfer + 1;
        if (rst && input_valid && input_ready_a) in_xfer <= in_xfer + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: pops expected beats on every output handshake, checks hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            hold_a = 1'b0;
            hold_b = 1'b0;
        end else begin
            if (output_valid_a && output_ready) begin
                if (qa.size() == 0) chk("a_unexpected_out", 32'(output_data_a), 32'hDEAD);
                else begin
                    e = qa.pop_front();
                    chk("a_data", 32'(output_data_a), 32'(e.d));
                    if (lat_en) chk("a_latency", cyc - e.c, 32'd1);
                end
            end
            if (output_valid_b && output_ready) begin
                if (qb.size() == 0) chk("b_unexpected_out", 32'(output_data_b), 32'hDEAD);
                else begin
                    e = qb.pop_front();
                    chk("b_data", 32'(output_data_b), 32'(e.d));
                    if (lat_en) chk("b_latency", cyc - e.c, 32'd1);
                end
            end
            if (output_valid_a && !output_ready) begin
                if (hold_a) chk("a_hold", 32'(output_data_a), 32'(hold_da));
                hold_a = 1'b1;
                hold_da = output_data_a;
            end else hold_a = 1'b0;
            if (output_valid_b && !output_ready) begin
                if (hold_b) chk("b_hold", 32'(output_data_b), 32'(hold_db));
                hold_b = 1'b1;
                hold_db = output_data_b;
            end else hold_b = 1'b0;
        end
    end

    task automatic push_exp(input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        e.c = cyc;
        e.d = ea;
        qa.push_back(e);
        e.d = eb;
        qb.push_back(e);
    endtask

    // Present one flag (and sample on pass); returns right after the transfer.
    task automatic send(input bit elim, input logic [15:0] din,
                        input logic [15:0] ea, input logic [15:0] eb);
        int  n = 0;
        bit  done = 1'b0;
        flag_valid  = 1'b1;
        flag_data   = elim;
        input_valid = !elim;
        input_data  = elim ? 16'h0 : din;
        while (!done) begin
            @(negedge clk);
            if (flag_ready_a) begin
                push_exp(ea, eb);
                done = 1'b1;
            end else if (n > 200) begin
                chk("send_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        flag_valid  = 1'b0;
        input_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);
    endtask

    initial begin
        int acc;
        logic [15:0] nxt;

        // Reset state, with traffic offered so readies must stay low.
        flag_valid  = 1'b1;
        input_valid = 1'b1;
        input_data  = 16'h1234;
        repeat (3) @(negedge clk);
        chk("rst_ov_a", 32'(output_valid_a), 32'd0);
        chk("rst_ov_b", 32'(output_valid_b), 32'd0);
        chk("rst_od_a", 32'(output_data_a), 32'd0);
        chk("rst_od_b", 32'(output_data_b), 32'd0);
        chk("rst_fr", 32'(flag_ready_a), 32'd0);
        chk("rst_ir", 32'(input_ready_a), 32'd0);
        idle();
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        output_ready = 1'b1;

        // Repeat fill from reset: flags E,P,E,E,P,E; inputs 5, 9.
        send(1, 0, 16'hFFFF, 16'd7);
        send(0, 5, 16'd5, 16'd5);
        send(1, 0, 16'hFFFF, 16'd5);
        send(1, 0, 16'hFFFF, 16'd5);
        send(0, 9, 16'd9, 16'd9);
        send(1, 0, 16'hFFFF, 16'd9);
        idle();
        drain();

        // Pass-only 1..4 back to back.
        send(0, 1, 16'd1, 16'd1);
        send(0, 2, 16'd2, 16'd2);
        send(0, 3, 16'd3, 16'd3);
        send(0, 4, 16'd4, 16'd4);
        idle();
        drain();

        // Constant fill: flags P,E,E,P,E; inputs 10, 20.
        @(posedge clk);
        #1;
        in_xfer = 0;
        flag_xfer = 0;
        send(0, 10, 16'd10, 16'd10);
        send(1, 0, 16'hFFFF, 16'd10);
        send(1, 0, 16'hFFFF, 16'd10);
        send(0, 20, 16'd20, 16'd20);
        send(1, 0, 16'hFFFF, 16'd20);
        idle();
        drain();
        chk("cfill_in_xfer", 32'(in_xfer), 32'd2);
        chk("cfill_flag_xfer", 32'(flag_xfer), 32'd5);

        // Pass flag with input stalled for 3 cycles.
        flag_valid  = 1'b1;
        flag_data   = 1'b0;
        input_valid = 1'b0;
        input_data  = 16'd77;
        repeat (3) begin
            @(negedge clk);
            chk("stall_flag_ready", 32'(flag_ready_a), 32'd0);
            chk("stall_input_ready", 32'(input_ready_a), 32'd0);
            chk("stall_no_out", 32'(output_valid_a), 32'd0);
            @(posedge clk);
            #1;
        end
        input_valid = 1'b1;
        @(negedge clk);
        chk("stall_release_fr", 32'(flag_ready_a), 32'd1);
        chk("stall_release_ir", 32'(input_ready_a), 32'd1);
        if (flag_ready_a) push_exp(16'd77, 16'd77);
        @(posedge clk);
        #1;
        idle();
        drain();

        // Backpressure: stall 5 cycles from empty with continuous pass traffic.
        lat_en = 1'b0;
        output_ready = 1'b0;
        nxt = 16'd100;
        acc = 0;
        flag_valid  = 1'b1;
        flag_data   = 1'b0;
        input_valid = 1'b1;
        input_data  = nxt;
        for (int i = 0; i < 11; i++) begin
            if (i == 5) output_ready = 1'b1;
            @(negedge clk);
            if (i == 4) begin
                chk("bp_flag_ready_low", 32'(flag_ready_a), 32'd0);
                chk("bp_input_ready_low", 32'(input_ready_a), 32'd0);
            end
            if (flag_ready_a) begin
                push_exp(nxt, nxt);
                nxt = nxt + 16'd1;
                if (i < 5) acc++;
            end
            @(posedge clk);
            #1;
            input_data = nxt;
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        idle();
        drain();
        lat_en = 1'b1;

        // Reset mid-stream with two beats buffered.
        lat_en = 1'b0;
        output_ready = 1'b0;
        send(0, 200, 16'd200, 16'd200);
        send(0, 201, 16'd201, 16'd201);
        idle();
        #2 rst = 1'b0;
        #1;
        chk("mrst_ov_a", 32'(output_valid_a), 32'd0);
        chk("mrst_ov_b", 32'(output_valid_b), 32'd0);
        chk("mrst_od_a", 32'(output_data_a), 32'd0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        output_ready = 1'b1;
        lat_en = 1'b1;
        send(1, 0, 16'hFFFF, 16'd7);
        send(0, 33, 16'd33, 16'd33);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
